// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types: machine word, RAM status, and the arbiter state encoding.
// Imported by mem_arbiter and arb_starve_ctr.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      I_ACC = 2'd1,
      D_ACC = 2'd2
   } arb_state_t;

   localparam int STARVE_W = 4;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of data grants completed while a fetch was waiting.
// sat_o tells the arbiter that the next fetch must be forced ahead of data.
module arb_starve_ctr
   import cpu_types_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic                clk_sys,
   input  logic                rst_i,
   input  logic                inc_i,
   input  logic                clr_i,
   output logic [STARVE_W-1:0] cnt_o,
   output logic                sat_o
);

   localparam logic [STARVE_W-1:0] SAT_VAL = STARVE_W'(STARVE_MAX);

   logic [STARVE_W-1:0] cnt_q;
   logic [STARVE_W-1:0] cnt_d;

   // Clear beats increment; the two never coincide in practice since a grant is one side or the other.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != SAT_VAL)) begin
         cnt_d = cnt_q + STARVE_W'(1);
      end
   end

   always_ff @(posedge clk_sys) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
   assign sat_o = (cnt_q == SAT_VAL);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access; data has priority,
// fetch is forced after STARVE_MAX data grants. Optional stats counters: MEM_ARBITER_STATS_EN.
//
// state | meaning
// IDLE  | no grant; arbitrate this cycle, RAM strobes low
// I_ACC | fetch granted; RAM driven from iaddr until ACCESS/ERROR/withdraw
// D_ACC | data granted; RAM driven from daddr/dstore until ACCESS/ERROR/withdraw
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dstore,
   output logic              ihit,
   output logic [DATA_W-1:0] iload,
   output logic              dhit,
   output logic [DATA_W-1:0] dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [DATA_W-1:0] ramstore,
   input  logic [DATA_W-1:0] ramload,
   input  ramstate_t         ramstate,
   output logic              ramerr
`ifdef MEM_ARBITER_STATS_EN
   ,
   output logic [15:0]       igrant_cnt,
   output logic [15:0]       dgrant_cnt,
   output logic [15:0]       starve_cnt
`endif
);

   arb_state_t          state_q;
   arb_state_t          state_d;
   logic [STARVE_W-1:0] dstreak;
   logic                streak_sat;
   logic                streak_inc;
   logic                streak_clr;
   logic                force_fetch;

   arb_starve_ctr #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve (
      .clk_sys (CLK),
      .rst_i   (RST),
      .inc_i   (streak_inc),
      .clr_i   (streak_clr),
      .cnt_o   (dstreak),
      .sat_o   (streak_sat)
   );

   // Hits and errors are masked while RST is high so a reset cycle never completes an access.
   always_comb begin
      state_d     = state_q;
      ramREN      = 1'b0;
      ramWEN      = 1'b0;
      ramaddr     = '0;
      ramstore    = '0;
      ihit        = 1'b0;
      iload       = '0;
      dhit        = 1'b0;
      dload       = '0;
      ramerr      = 1'b0;
      streak_inc  = 1'b0;
      streak_clr  = 1'b0;
      force_fetch = 1'b0;
      case (state_q)
         IDLE: begin
            if (iREN && streak_sat) begin
               state_d     = I_ACC;
               force_fetch = 1'b1;
            end else if (dREN || dWEN) begin
               state_d = D_ACC;
            end else if (iREN) begin
               state_d = I_ACC;
            end
         end
         D_ACC: begin
            ramaddr  = daddr;
            ramstore = dstore;
            if (!(dREN || dWEN)) begin
               state_d = IDLE;
            end else begin
               ramWEN = dWEN;
               ramREN = !dWEN;
               if (ramstate == ACCESS) begin
                  dhit       = !RST;
                  dload      = (!RST && !dWEN) ? ramload : '0;
                  streak_inc = iREN;
                  state_d    = IDLE;
               end else if (ramstate == ERROR) begin
                  ramerr  = !RST;
                  state_d = IDLE;
               end
            end
         end
         I_ACC: begin
            ramaddr = iaddr;
            if (!iREN) begin
               state_d = IDLE;
            end else begin
               ramREN = 1'b1;
               if (ramstate == ACCESS) begin
                  ihit       = !RST;
                  iload      = RST ? '0 : ramload;
                  streak_clr = 1'b1;
                  state_d    = IDLE;
               end else if (ramstate == ERROR) begin
                  ramerr  = !RST;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

`ifdef MEM_ARBITER_STATS_EN
   logic [15:0] igrant_q;
   logic [15:0] dgrant_q;
   logic [15:0] starve_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         igrant_q <= '0;
         dgrant_q <= '0;
         starve_q <= '0;
      end else begin
         if (ihit && (igrant_q != 16'hFFFF)) igrant_q <= igrant_q + 16'd1;
         if (dhit && (dgrant_q != 16'hFFFF)) dgrant_q <= dgrant_q + 16'd1;
         if (force_fetch && (starve_q != 16'hFFFF)) starve_q <= starve_q + 16'd1;
      end
   end

   assign igrant_cnt = igrant_q;
   assign dgrant_cnt = dgrant_q;
   assign starve_cnt = starve_q;
`endif

endmodule
